// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control FSM: opcode constants and state type.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

// File: rtl/proc_ctrl_if.sv
// Control bundle between the sequencer and the datapath: instruction/start inputs and
// the register/bus enables the sequencer produces.
interface proc_ctrl_if;
  logic       Run;
  logic [8:0] IR;
  logic       G_nz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       DINout;
  logic       AddSub;
  logic       Done;

  modport master (
    input  Run, IR, G_nz,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
  );

  modport slave (
    output Run, IR, G_nz,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
  );
endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[w_i] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl.sv
// Four-step instruction sequencer (T0 fetch, T1..T3 execute) for a simple bus processor.
// Optional mvnz instruction is enabled by defining PROC_CTRL_MVNZ_EN.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic         Clock,
  input  logic         set_0,
  proc_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  logic [2:0] op, rx, ry;
  logic [2:0] routSel;
  logic       rinEn, routEn;
  logic       irin, ain, gin, gout, dinout, addSub, done;
  logic       isArith;

  assign op      = bus.IR[8:6];
  assign rx      = bus.IR[5:3];
  assign ry      = bus.IR[2:0];
  assign isArith = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge Clock) begin
    if (set_0) state_q <= T0;
    else       state_q <= state_d;
  end

  // Rin always targets Rx; Rout picks Rx or Ry depending on the step.
  always_comb begin
    state_d = state_q;
    irin    = 1'b0;
    rinEn   = 1'b0;
    routEn  = 1'b0;
    routSel = ry;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    dinout  = 1'b0;
    addSub  = 1'b0;
    done    = 1'b0;

    case (state_q)
      T0: begin
        irin = bus.Run;
        if (bus.Run) state_d = T1;
      end
      T1: begin
        state_d = T0;
        case (op)
          OP_MV: begin
            routEn = 1'b1;
            rinEn  = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rinEn  = 1'b1;
            done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            routSel = rx;
            routEn  = 1'b1;
            ain     = 1'b1;
            state_d = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            routEn = bus.G_nz;
            rinEn  = bus.G_nz;
            done   = 1'b1;
          end
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        state_d = T0;
        if (isArith) begin
          routEn  = 1'b1;
          gin     = 1'b1;
          addSub  = bus.IR[6];
          state_d = T3;
        end
      end
      T3: begin
        state_d = T0;
        if (isArith) begin
          gout  = 1'b1;
          rinEn = 1'b1;
          done  = 1'b1;
        end
      end
      default: state_d = T0;
    endcase

    // Reset silences every enable immediately, even mid-instruction.
    if (set_0) begin
      irin   = 1'b0;
      rinEn  = 1'b0;
      routEn = 1'b0;
      ain    = 1'b0;
      gin    = 1'b0;
      gout   = 1'b0;
      dinout = 1'b0;
      addSub = 1'b0;
      done   = 1'b0;
    end
  end

  dec3to8 uRinDec (
    .w_i  (rx),
    .en_i (rinEn),
    .y_o  (bus.Rin)
  );

  dec3to8 uRoutDec (
    .w_i  (routSel),
    .en_i (routEn),
    .y_o  (bus.Rout)
  );

  assign bus.IRin   = irin;
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.Gout   = gout;
  assign bus.DINout = dinout;
  assign bus.AddSub = addSub;
  assign bus.Done   = done;

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: directed cycle table, then random traffic against an instruction-level model.
module tb_proc_ctrl;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [8:0] ir;
    logic       gnz;
    outs_t      exp;
    string      name;
  } vec_t;

  logic Clock = 1'b0;
  logic set_0;
  int   errors = 0;
  int   checks = 0;

  outs_t expQ[$];
  vec_t  vecs[$];

  proc_ctrl_if bus();

  proc_ctrl dut (
    .Clock (Clock),
    .set_0 (set_0),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  function automatic outs_t mkOut(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                  input logic ain, input logic gin, input logic gout,
                                  input logic din, input logic as, input logic done);
    outs_t o;
    o.irin = irin; o.rin = rin; o.rout = rout; o.ain = ain; o.gin = gin;
    o.gout = gout; o.dinout = din; o.addsub = as; o.done = done;
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("irin=%b rin=%b rout=%b ain=%b gin=%b gout=%b din=%b as=%b done=%b",
                     o.irin, o.rin, o.rout, o.ain, o.gin, o.gout, o.dinout, o.addsub, o.done);
  endfunction

  function automatic void addVec(input logic rst, input logic run, input logic [8:0] ir,
                                 input logic gnz, input outs_t exp, input string name);
    vec_t v;
    v.rst = rst; v.run = run; v.ir = ir; v.gnz = gnz; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  // Instruction-level model: the list of per-cycle outputs an issued instruction produces.
  task automatic buildSteps(input logic [8:0] ir, input logic gnz);
    logic [7:0] rxh, ryh;
    rxh = 8'd1 << ir[5:3];
    ryh = 8'd1 << ir[2:0];
    case (ir[8:6])
      3'b000: expQ.push_back(mkOut(0, rxh, ryh, 0, 0, 0, 0, 0, 1));
      3'b001: expQ.push_back(mkOut(0, rxh, 8'h00, 0, 0, 0, 1, 0, 1));
      3'b010, 3'b011: begin
        expQ.push_back(mkOut(0, 8'h00, rxh, 1, 0, 0, 0, 0, 0));
        expQ.push_back(mkOut(0, 8'h00, ryh, 0, 1, 0, 0, ir[8:6] == 3'b011, 0));
        expQ.push_back(mkOut(0, rxh, 8'h00, 0, 0, 1, 0, 0, 1));
      end
`ifdef PROC_CTRL_MVNZ_EN
      3'b100: begin
        if (gnz) expQ.push_back(mkOut(0, rxh, ryh, 0, 0, 0, 0, 0, 1));
        else     expQ.push_back(mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
      end
`endif
      default: expQ.push_back(mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic applyStimulus(input logic rst, input logic run, input logic [8:0] ir, input logic gnz);
    set_0    = rst;
    bus.Run  = run;
    bus.IR   = ir;
    bus.G_nz = gnz;
  endtask

  task automatic checkOutput(input outs_t exp, input string name);
    outs_t act;
    int    drivers;
    #1;
    act = mkOut(bus.IRin, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout, bus.DINout, bus.AddSub, bus.Done);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
    drivers = $countones(act.rout) + int'(act.gout) + int'(act.dinout);
    checks++;
    if (drivers > 1) begin
      errors++;
      $display("[TB] FAIL %s busExclusive: got %0d drivers, expected at most 1", name, drivers);
    end
    checks++;
    if (!$onehot0(act.rin) || !$onehot0(act.rout)) begin
      errors++;
      $display("[TB] FAIL %s oneHot: got rin=%b rout=%b, expected zero or one-hot", name, act.rin, act.rout);
    end
  endtask

  initial begin
    outs_t z, f;
    logic [8:0] curIr;
    logic curGnz, run, rst;
    z = mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    f = mkOut(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    addVec(1, 1, 9'b010_001_010, 0, z, "rstHold0");
    addVec(1, 1, 9'b010_001_010, 0, z, "rstHold1");
    addVec(0, 1, 9'b010_001_010, 0, f, "rstReleaseIRin");
    addVec(0, 0, 9'b010_001_010, 0, mkOut(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0), "addT1");
    addVec(0, 0, 9'b010_001_010, 0, mkOut(0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0), "addT2");
    addVec(0, 0, 9'b010_001_010, 0, mkOut(0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 1), "addT3");
    addVec(0, 0, 9'b010_001_010, 0, z, "addIdle");
    addVec(0, 1, 9'b001_011_000, 0, f, "mviFetch");
    addVec(0, 0, 9'b001_011_000, 0, mkOut(0, 8'h08, 8'h00, 0, 0, 0, 1, 0, 1), "mviT1");
    addVec(0, 0, 9'b001_011_000, 0, z, "mviIdle");
    addVec(0, 1, 9'b011_101_110, 0, f, "subRstFetch");
    addVec(0, 0, 9'b011_101_110, 0, mkOut(0, 8'h00, 8'h20, 1, 0, 0, 0, 0, 0), "subRstT1");
    addVec(1, 0, 9'b011_101_110, 0, z, "subRstInT2");
    addVec(0, 0, 9'b011_101_110, 0, z, "subAbandoned");
    addVec(0, 1, 9'b011_101_110, 0, f, "subFetch");
    addVec(0, 0, 9'b011_101_110, 0, mkOut(0, 8'h00, 8'h20, 1, 0, 0, 0, 0, 0), "subT1");
    addVec(0, 0, 9'b011_101_110, 0, mkOut(0, 8'h00, 8'h40, 0, 1, 0, 0, 1, 0), "subT2");
    addVec(0, 0, 9'b011_101_110, 0, mkOut(0, 8'h20, 8'h00, 0, 0, 1, 0, 0, 1), "subT3");
    addVec(0, 0, 9'b011_101_110, 0, z, "subIdle");
    addVec(0, 1, 9'b100_000_111, 0, f, "mvnzFetch0");
    addVec(0, 0, 9'b100_000_111, 0, mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), "mvnzGnz0");
    addVec(0, 1, 9'b100_000_111, 1, f, "mvnzFetch1");
`ifdef PROC_CTRL_MVNZ_EN
    addVec(0, 0, 9'b100_000_111, 1, mkOut(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1), "mvnzGnz1");
`else
    addVec(0, 0, 9'b100_000_111, 1, mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), "mvnzGnz1");
`endif
    addVec(0, 1, 9'b111_010_011, 0, f, "undefFetch");
    addVec(0, 0, 9'b111_010_011, 0, mkOut(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), "undefT1");
    for (int i = 0; i < 3; i++) begin
      addVec(0, 1, 9'b000_000_111, 0, f, $sformatf("mvStreamFetch%0d", i));
      addVec(0, 1, 9'b000_000_111, 0, mkOut(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1), $sformatf("mvStreamT1_%0d", i));
    end
    addVec(0, 0, 9'b000_000_111, 0, z, "mvStreamIdle");

    foreach (vecs[i]) begin
      @(negedge Clock);
      applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].ir, vecs[i].gnz);
      checkOutput(vecs[i].exp, vecs[i].name);
    end

    // Random traffic; IR and G_nz only change while the model says the sequencer is idle.
    expQ.delete();
    curIr  = 9'd0;
    curGnz = 1'b0;
    for (int c = 0; c < 500; c++) begin
      outs_t e;
      @(negedge Clock);
      if (expQ.size() == 0) begin
        curIr  = 9'($urandom);
        curGnz = 1'($urandom);
      end
      run = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 24) == 0);
      applyStimulus(rst, run, curIr, curGnz);
      if (rst) begin
        expQ.delete();
        e = z;
      end else if (expQ.size() == 0) begin
        e = mkOut(run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        if (run) buildSteps(curIr, curGnz);
      end else begin
        e = expQ.pop_front();
      end
      checkOutput(e, $sformatf("rand%0d_ir%b", c, curIr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port set_0  input  1  synchronous, active-high reset.
REQ-003 SHALL have port Run  input  1  start request, sampled in T0.
REQ-004 SHALL have port IR  input  9  latched instruction, fields III=IR[8:6], XXX=IR[5:3] (Rx), YYY=IR[2:0] (Ry).
REQ-005 SHALL have port G_nz  input  1  G register non-zero flag; used only when PROC_CTRL_MVNZ_EN is defined.
REQ-006 SHALL have port IRin  output  1  IR register load enable.
REQ-007 SHALL have port Rin  output  8  one-hot R0..R7 load enables.
REQ-008 SHALL have port Rout  output  8  one-hot R0..R7 bus drive selects.
REQ-009 SHALL have ports Ain, Gin, Gout, DINout, AddSub, Done  output  1 each  A/G load, G bus drive, DIN bus drive, 0=add 1=sub, instruction complete.

Function
REQ-010 SHALL implement a 4-state FSM T0 (idle/fetch), T1, T2, T3 with a registered state, and combinational outputs derived from state, IR, Run, G_nz and set_0.
REQ-011 SHALL, in T0: IRin = Run & ~set_0; next state T1 if Run, else T0; all other outputs 0.
REQ-012 SHALL ignore Run in T1..T3.
REQ-013 mv (000), T1: Rout=onehot(Ry), Rin=onehot(Rx), Done=1; next T0.
REQ-014 mvi (001), T1: DINout=1, Rin=onehot(Rx), Done=1; next T0.
REQ-015 add (010) / sub (011): T1 Rout=onehot(Rx), Ain=1; T2 Rout=onehot(Ry), Gin=1, AddSub=IR[6]; T3 Gout=1, Rin=onehot(Rx), Done=1; next T0.
REQ-016 Undefined opcodes (101-111, and 100 without the macro), T1: Done=1 only, no enables; next T0.
REQ-017 SHALL never assert more than one bus driver (any Rout bit, Gout, DINout) in one cycle; Rin and Rout SHALL each be zero or one-hot.
REQ-018 Latency from Run sampled in T0 to Done: 1 cycle (mv/mvi/mvnz/undefined), 3 cycles (add/sub); with Run held high, instructions issue back-to-back with T0 between them.
REQ-019 AddSub SHALL be 0 outside T2 of add/sub.

Reset
REQ-020 set_0=1 at a rising edge SHALL force state T0 regardless of current state, Run or IR.
REQ-021 While set_0=1, all outputs SHALL be 0, including IRin and Done.
REQ-022 Reset mid-instruction SHALL abandon it; no Rin/Done SHALL be produced for the abandoned instruction.

Configuration
REQ-023 Macro PROC_CTRL_MVNZ_EN defined: opcode 100 (mvnz), T1: if G_nz=1, Rout=onehot(Ry) and Rin=onehot(Rx); Done=1 regardless; next T0.
REQ-024 Macro undefined: opcode 100 treated per REQ-016; G_nz ignored; port list unchanged.

Structure
REQ-025 A shared package proc_pkg SHALL hold the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ) and the state type/encodings T0..T3.
REQ-026 A sub-module dec3to8 (3-bit to 8-bit one-hot decoder with enable) SHALL be instantiated for Rin and Rout generation.

Verification
REQ-027 set_0=1 for 2 cycles with Run=1, IR=9'b010_001_010 -> state T0, all outputs 0 throughout; after release, IRin=1 in the first cycle.
REQ-028 IR=9'b001_011_000, Run pulsed 1 cycle -> next cycle DINout=1, Rin=8'b0000_1000, Done=1; following cycle T0, Done=0.
REQ-029 IR=9'b010_001_010 (add R1,R2) -> T1 Rout=8'b0000_0010, Ain=1; T2 Rout=8'b0000_0100, Gin=1, AddSub=0; T3 Gout=1, Rin=8'b0000_0010, Done=1.
REQ-030 IR=9'b011_101_110 (sub), set_0=1 during T2 -> next cycle T0, outputs 0, no Done or Rin observed.
REQ-031 IR=9'b100_000_111 with macro: G_nz=0 -> T1 Done=1, Rin=0, Rout=0; G_nz=1 -> Rout=8'b1000_0000, Rin=8'b0000_0001, Done=1; without macro both cases -> Done=1, Rin=0, Rout=0.
REQ-032 Run held 1, IR=9'b000_000_111 constant for 6 cycles -> Done asserted every second cycle (T0/T1 alternation); bus-driver exclusivity and Rin/Rout one-hot assertions checked every cycle of all scenarios.
